// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller:
// stall bus encodings, FSM state codes and the reset-asserted level.
package pipe_stall_ctrl_pkg;

    typedef logic [5:0] stall_bus_t;

    // Hold vector bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;

    localparam logic RST_ASSERTED = 1'b0;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_EX_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    // Only ops longer than one cycle need the EX_WAIT state.
    function automatic logic isLongOp(input logic [5:0] n);
        return n >= 6'd2;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_perf_cnt.sv
// 16-bit saturating stall-cycle counter; clear has priority over increment.
module stall_perf_cnt
    import pipe_stall_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        clr_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 16'h0000;
        end else if (inc_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ASSERTED) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: decode/EX stalls, multi-cycle EX wait and
// one-cycle flush with registered redirect target.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        ex_start,
    input  logic [5:0]  ex_cycles,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    input  logic        cnt_clr,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [15:0] stall_cnt
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] new_pc_q, new_pc_d;

    always_ff @(posedge clk) begin
        if (rst == RST_ASSERTED) begin
            state_q  <= ST_RUN;
            cnt_q    <= 6'd0;
            new_pc_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            new_pc_q <= new_pc_d;
        end
    end

    // A flush request overrides everything, including an in-flight EX wait.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        new_pc_d = new_pc_q;
        if (flush_req) begin
            state_d  = ST_FLUSH;
            cnt_d    = 6'd0;
            new_pc_d = flush_pc;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_start && isLongOp(ex_cycles)) begin
                        state_d = ST_EX_WAIT;
                        cnt_d   = ex_cycles - 6'd1;
                    end
                end
                ST_EX_WAIT: begin
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q <= 6'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 6'd0;
                    end
                end
                ST_FLUSH: state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // In RUN a same-cycle flush request suppresses the stall of the younger op.
    always_comb begin
        stall = STALL_NONE;
        if (rst != RST_ASSERTED) begin
            case (state_q)
                ST_RUN: begin
                    if (flush_req) begin
                        stall = STALL_NONE;
                    end else if (ex_start && (ex_cycles != 6'd0)) begin
                        stall = STALL_EX;
                    end else if (stallreq_id) begin
                        stall = STALL_ID;
                    end
                end
                ST_EX_WAIT: stall = STALL_EX;
                default:    stall = STALL_NONE;
            endcase
        end
    end

    assign flush  = (state_q == ST_FLUSH);
    assign new_pc = new_pc_q;

    stall_perf_cnt u_perf_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall != STALL_NONE),
        .clr_i   (cnt_clr),
        .count_o (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench: per-cycle comparison against a behavioural model plus
// directed scenarios with hand-computed expectations and a random phase.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        ex_start;
    logic [5:0]  ex_cycles;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic        cnt_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [15:0] stall_cnt;

    int vectors     = 0;
    int miscompares = 0;
    bit modelOn     = 0;

    // Model state: remaining EX stall cycles after the current one, etc.
    int          mRem   = 0;
    bit          mFlush = 0;
    logic [31:0] mPc    = 32'h0;
    int          mCnt   = 0;
    logic [5:0]  expStall;

    localparam logic [31:0] PC_A = 32'h8000_1000;
    localparam logic [31:0] PC_B = 32'h8000_2004;

    pipe_stall_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .ex_start    (ex_start),
        .ex_cycles   (ex_cycles),
        .flush_req   (flush_req),
        .flush_pc    (flush_pc),
        .cnt_clr     (cnt_clr),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, return at the falling edge.
    task automatic applyStimulus(input logic r, input logic sid, input logic exs,
                                 input logic [5:0] n, input logic fr,
                                 input logic [31:0] fpc, input logic clr);
        @(posedge clk);
        #1;
        rst         = r;
        stallreq_id = sid;
        ex_start    = exs;
        ex_cycles   = n;
        flush_req   = fr;
        flush_pc    = fpc;
        cnt_clr     = clr;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
    endtask

    // Behavioural reference: expected outputs at the falling edge, state advance at the rising edge.
    initial begin
        bit wasFlush;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1)                        expStall = 6'b000000;
            else if (mFlush)                         expStall = 6'b000000;
            else if (mRem > 0)                       expStall = 6'b001111;
            else if (flush_req)                      expStall = 6'b000000;
            else if (ex_start && ex_cycles != 6'd0)  expStall = 6'b001111;
            else if (stallreq_id)                    expStall = 6'b000111;
            else                                     expStall = 6'b000000;
            if (modelOn) begin
                checkOutput("model_stall", {26'h0, stall}, {26'h0, expStall});
                checkOutput("model_flush", {31'h0, flush}, {31'h0, mFlush});
                checkOutput("model_new_pc", new_pc, mPc);
                checkOutput("model_stall_cnt", {16'h0, stall_cnt}, mCnt);
            end
            @(posedge clk);
            if (rst !== 1'b1) begin
                mRem = 0; mFlush = 0; mPc = 32'h0; mCnt = 0;
            end else begin
                if (cnt_clr)                               mCnt = 0;
                else if (expStall != 6'd0 && mCnt < 65535) mCnt = mCnt + 1;
                if (flush_req) begin
                    mFlush = 1; mPc = flush_pc; mRem = 0;
                end else begin
                    wasFlush = mFlush;
                    mFlush   = 0;
                    if (mRem > 0)
                        mRem = mRem - 1;
                    else if (!wasFlush && ex_start && ex_cycles >= 6'd2)
                        mRem = int'(ex_cycles) - 1;
                end
            end
        end
    end

    initial begin
        rst = 1'b0; stallreq_id = 1'b0; ex_start = 1'b0; ex_cycles = 6'd0;
        flush_req = 1'b0; flush_pc = 32'h0; cnt_clr = 1'b0;

        applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
        modelOn = 1;
        applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
        idle();
        checkOutput("reset_stall", {26'h0, stall}, 32'h0);
        checkOutput("reset_flush", {31'h0, flush}, 32'h0);
        checkOutput("reset_new_pc", new_pc, 32'h0);
        checkOutput("reset_stall_cnt", {16'h0, stall_cnt}, 32'h0);

        // Decode hazard for three cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
            checkOutput("id_stall", {26'h0, stall}, 32'h07);
        end
        idle();
        checkOutput("id_stall_release", {26'h0, stall}, 32'h0);
        checkOutput("id_stall_cnt", {16'h0, stall_cnt}, 32'd3);

        // Five-cycle EX op, with a decode hazard raised mid-wait.
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd5, 1'b0, 32'h0, 1'b0);
        checkOutput("ex5_c0", {26'h0, stall}, 32'h0F);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1'b1, (i == 2), 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
            checkOutput("ex5_wait", {26'h0, stall}, 32'h0F);
        end
        idle();
        checkOutput("ex5_done", {26'h0, stall}, 32'h0);
        checkOutput("ex5_cnt", {16'h0, stall_cnt}, 32'd8);

        // N=0 and N=1 ops.
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 32'h0, 1'b0);
        checkOutput("ex0_stall", {26'h0, stall}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd1, 1'b0, 32'h0, 1'b0);
        checkOutput("ex1_stall", {26'h0, stall}, 32'h0F);
        idle();
        checkOutput("ex1_after", {26'h0, stall}, 32'h0);

        // Flush during the third EX_WAIT cycle of a ten-cycle op.
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd10, 1'b0, 32'h0, 1'b0);
        idle();
        idle();
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 32'hBFC00380, 1'b0);
        checkOutput("exflush_req_cycle", {26'h0, stall}, 32'h0F);
        idle();
        checkOutput("exflush_flush", {31'h0, flush}, 32'h1);
        checkOutput("exflush_new_pc", new_pc, 32'hBFC00380);
        checkOutput("exflush_stall", {26'h0, stall}, 32'h0);
        idle();
        checkOutput("exflush_run_flush", {31'h0, flush}, 32'h0);
        checkOutput("exflush_run_stall", {26'h0, stall}, 32'h0);

        // Back-to-back flushes.
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, PC_A, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, PC_B, 1'b0);
        checkOutput("dflush_1_flush", {31'h0, flush}, 32'h1);
        checkOutput("dflush_1_pc", new_pc, PC_A);
        idle();
        checkOutput("dflush_2_flush", {31'h0, flush}, 32'h1);
        checkOutput("dflush_2_pc", new_pc, PC_B);
        idle();
        checkOutput("dflush_end_flush", {31'h0, flush}, 32'h0);
        checkOutput("dflush_hold_pc", new_pc, PC_B);

        // Saturation: clear, count up to FFFE, then push past full.
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 65534; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
        checkOutput("sat_fffe", {16'h0, stall_cnt}, 32'hFFFE);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
        idle();
        checkOutput("sat_ffff", {16'h0, stall_cnt}, 32'hFFFF);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1);
        idle();
        checkOutput("sat_clr", {16'h0, stall_cnt}, 32'h0);

        // Reset in the middle of an EX wait.
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd8, 1'b0, 32'h0, 1'b0);
        idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_mid_stall", {26'h0, stall}, 32'h0);
        idle();
        checkOutput("rst_after_stall", {26'h0, stall}, 32'h0);
        checkOutput("rst_after_flush", {31'h0, flush}, 32'h0);
        checkOutput("rst_after_pc", new_pc, 32'h0);
        checkOutput("rst_after_cnt", {16'h0, stall_cnt}, 32'h0);

        // Random phase, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] n;
            n = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
            applyStimulus(($urandom_range(0, 99) != 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 4) == 0),
                          n,
                          ($urandom_range(0, 15) == 0),
                          $urandom,
                          ($urandom_range(0, 49) == 0));
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset; reset-asserted encoding 1'b0.
- stallreq_id  in  1  decode load-use hazard; level, same-cycle.
- ex_start  in  1  single-cycle pulse: multi-cycle op enters EX.
- ex_cycles  in  6  total stall length N for that op; sampled only with ex_start.
- flush_req  in  1  exception/redirect pulse.
- flush_pc  in  32  redirect target; sampled with flush_req.
- cnt_clr  in  1  clears stall_cnt.
- stall  out  6  stage hold vector: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
- flush  out  1  registered pipeline flush pulse.
- new_pc  out  32  registered redirect target; valid when flush=1.
- stall_cnt  out  16  saturating count of cycles with stall!=0.

Function
REQ-003 FSM states SHALL be RUN, EX_WAIT and FLUSH, with a 6-bit down-counter cnt.
REQ-004 Input priority SHALL be: flush_req > ex_start > stallreq_id.
REQ-005 In RUN, stall SHALL be computed combinationally in the same cycle:
- 6'b001111 when ex_start=1 and N>=1;
- else 6'b000111 when stallreq_id=1;
- else 6'b000000.
REQ-006 An ex_start with N=0 SHALL cause no stall and no state change.
REQ-007 An ex_start with N=1 SHALL stall for that cycle only and remain in RUN.
REQ-008 An ex_start with N>=2 SHALL enter EX_WAIT with cnt=N-1.
REQ-009 In EX_WAIT:
- stall SHALL be 6'b001111 regardless of stallreq_id;
- cnt SHALL decrement each cycle;
- the cycle with cnt==1 is the last stalled cycle, and the next state SHALL be RUN.
- Result: exactly N consecutive stall cycles counted from the ex_start cycle.
REQ-010 ex_start SHALL be ignored in EX_WAIT and FLUSH.
REQ-011 flush_req in any state SHALL take effect on the next cycle:
- next state FLUSH, cnt cleared, new_pc<=flush_pc;
- any EX_WAIT is aborted.
REQ-012 In FLUSH:
- flush SHALL be 1 and stall 6'b000000, for exactly one cycle;
- next state RUN, unless flush_req is asserted again, which re-enters FLUSH with the newer flush_pc.
REQ-013 flush SHALL be 0 in every state other than FLUSH.
REQ-014 new_pc SHALL hold its last value while flush=0.
REQ-015 stall_cnt:
- SHALL increment by 1 on each clock edge whose cycle had stall!=0;
- SHALL saturate at 16'hFFFF;
- cnt_clr SHALL set it to 0 and wins over increment in the same cycle.
REQ-016 stall SHALL always be one of 6'b000000, 6'b000111, 6'b001111; bits 5:4 SHALL always be 0.

Reset
REQ-017 While rst=0 at a clock edge, the block SHALL load: state=RUN, cnt=0, flush=0, new_pc=32'h0, stall_cnt=0.
REQ-018 stall SHALL be forced to 6'b000000 combinationally while rst=0.
REQ-019 Reset asserted mid-EX_WAIT or mid-FLUSH SHALL abandon the operation with no residual stall or flush after release.

Structure
REQ-020 The shared defines file SHALL carry:
- `StallBus 5:0;
- stall encodings (STALL_NONE, STALL_ID, STALL_EX);
- FSM state codes;
- the reset-asserted value used for rst.
REQ-021 The saturating counter SHALL be a sub-module, stall_perf_cnt (16-bit, inc, clr).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- stallreq_id=1 for 3 cycles in RUN -> stall=6'b000111 in exactly those 3 cycles; stall_cnt=3.
- ex_start, ex_cycles=5 -> stall=6'b001111 for 5 consecutive cycles starting at the ex_start cycle; then RUN with stall=0.
- ex_start with ex_cycles=0 -> no stall; ex_start with ex_cycles=1 -> single stall cycle; state stays RUN.
- flush_req with flush_pc=32'hBFC00380 during the 3rd cycle of a 10-cycle EX_WAIT -> next cycle flush=1, new_pc=32'hBFC00380, stall=0; the following cycle RUN, no stall.
- flush_req on two consecutive cycles (pc A then pc B) -> flush=1 for two cycles, new_pc=A then B.
- stall_cnt preset to 16'hFFFE by 2 stall cycles from near-full, then 3 more stall cycles -> holds 16'hFFFF; cnt_clr -> 0.
- rst=0 asserted mid-EX_WAIT -> stall=0 in the same cycle, all registers at reset values after the edge.
